// File: rtl/pop_count_pipe.sv
// Pipelined population counter: leaf popcounts feed a registered binary adder tree,
// with a travelling valid bit, global stall and a saturating result accumulator.
module pop_count_pipe #(
    parameter int unsigned N      = 64,
    parameter int unsigned LEAF_W = 8,
    parameter int unsigned ACC_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 valid_i,
    input  logic [N-1:0]         x,
    input  logic                 acc_clr,
    output logic                 valid_o,
    output logic [$clog2(N):0]   y,
    output logic [ACC_W-1:0]     acc_o,
    output logic                 acc_sat
);

    localparam int unsigned G       = (N + LEAF_W - 1) / LEAF_W;
    localparam int unsigned L       = $clog2(G);
    localparam int unsigned LATENCY = L + 1;
    localparam int unsigned YW      = $clog2(N) + 1;
    localparam int unsigned GP      = 2 ** L;
    localparam int unsigned XPW     = GP * LEAF_W;
    localparam int unsigned LW0     = $clog2(LEAF_W) + 1;
    localparam int unsigned AW1     = ACC_W + 1;

    logic [XPW-1:0] xp;
    logic [L:0]     vld;
    logic           pre_v;
    logic           load;
    logic [YW-1:0]  new_y;

    // Zero-extend to a power-of-two number of leaves so the tree is balanced.
    assign xp = XPW'(x);

    for (genvar l = 0; l <= L; l++) begin : lv
        localparam int unsigned W = LW0 + l;
        localparam int unsigned M = GP >> l;

        logic [M-1:0][W-1:0] d;
        logic [M-1:0][W-1:0] q;

        if (l == 0) begin : g_leaf
            always_comb begin
                d = '0;
                for (int unsigned g = 0; g < M; g++) begin
                    for (int unsigned b = 0; b < LEAF_W; b++) begin
                        d[g] = d[g] + W'(xp[g*LEAF_W + b]);
                    end
                end
            end
        end else begin : g_add
            // Each level is one bit wider than its inputs, so carries are kept.
            always_comb begin
                d = '0;
                for (int unsigned i = 0; i < M; i++) begin
                    d[i] = W'(lv[l-1].q[2*i]) + W'(lv[l-1].q[2*i + 1]);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                q <= '0;
            end else if (en) begin
                q <= d;
            end
        end
    end

    if (L == 0) begin : g_v_single
        assign pre_v = valid_i;
        always_ff @(posedge clk) begin
            if (rst) begin
                vld <= '0;
            end else if (en) begin
                vld <= valid_i;
            end
        end
    end else begin : g_v_chain
        assign pre_v = vld[L-1];
        always_ff @(posedge clk) begin
            if (rst) begin
                vld <= '0;
            end else if (en) begin
                vld <= {vld[L-1:0], valid_i};
            end
        end
    end

    assign valid_o = vld[L];
    assign y       = YW'(lv[L].q[0]);
    assign new_y   = YW'(lv[L].d[0]);
    assign load    = en & pre_v;

    logic [ACC_W-1:0] acc_base;
    logic [AW1-1:0]   acc_sum;
    logic             acc_ovf;

    // Clear-then-add: a coincident clear zeroes the base before the new result is added.
    always_comb begin
        acc_base = acc_clr ? '0 : acc_o;
        acc_sum  = AW1'(acc_base) + AW1'(new_y);
        acc_ovf  = acc_sum[ACC_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_o   <= '0;
            acc_sat <= 1'b0;
        end else if (load) begin
            acc_o   <= acc_ovf ? '1 : acc_sum[ACC_W-1:0];
            acc_sat <= (acc_sat & ~acc_clr) | acc_ovf;
        end else if (acc_clr) begin
            acc_o   <= '0;
            acc_sat <= 1'b0;
        end
    end

    // Compile-time parameter sanity.
    if (LATENCY != L + 1 || ACC_W < YW || LEAF_W < 1 || LEAF_W > N) begin : g_bad_params
        $error("pop_count_pipe: illegal parameter combination");
    end

endmodule

// File: tb/tb_pop_count_pipe.sv
// Randomised and directed checks of pop_count_pipe against a queue-based reference
// model (N=64/LEAF_W=8/ACC_W=8 instance plus an N=13/LEAF_W=4 instance).
module tb_pop_count_pipe;

    localparam int LAT  = 4;
    localparam int LAT1 = 3;
    localparam int AMAX = 255;

    logic        clk = 1'b0;
    logic        rst0, en0, vi0, clr0;
    logic [63:0] x0;
    logic        vo0, sat0;
    logic [6:0]  y0;
    logic [7:0]  acc0;

    logic        en1, vi1;
    logic [12:0] x1;
    logic        vo1, sat1;
    logic [4:0]  y1;
    logic [15:0] acc1;

    int vectors = 0;
    int errs    = 0;

    typedef struct { bit v; int c; } ent_t;
    ent_t hist[$];
    bit   m_v;
    int   m_y;
    int   m_acc;
    bit   m_sat;

    always #5 clk = ~clk;

    pop_count_pipe #(.N(64), .LEAF_W(8), .ACC_W(8)) u0 (
        .clk(clk), .rst(rst0), .en(en0), .valid_i(vi0), .x(x0), .acc_clr(clr0),
        .valid_o(vo0), .y(y0), .acc_o(acc0), .acc_sat(sat0)
    );

    pop_count_pipe #(.N(13), .LEAF_W(4), .ACC_W(16)) u1 (
        .clk(clk), .rst(rst0), .en(en1), .valid_i(vi1), .x(x1), .acc_clr(1'b0),
        .valid_o(vo1), .y(y1), .acc_o(acc1), .acc_sat(sat1)
    );

    task automatic set_in(input bit e, input bit v, input logic [63:0] xv, input bit c);
        en0 = e; vi0 = v; x0 = xv; clr0 = c;
    endtask

    // Advance one clock and update the reference model for u0 from the applied inputs.
    task automatic cyc();
        bit loaded;
        @(posedge clk);
        if (rst0) begin
            hist.delete();
            m_v = 0; m_y = 0; m_acc = 0; m_sat = 0;
        end else begin
            loaded = 0;
            if (en0) begin
                hist.push_back('{vi0, $countones(x0)});
                if (hist.size() > LAT) void'(hist.pop_front());
                if (hist.size() == LAT) begin
                    m_v = hist[0].v;
                    m_y = hist[0].c;
                end else begin
                    m_v = 0;
                end
                loaded = m_v;
            end
            if (clr0) begin
                m_acc = 0; m_sat = 0;
            end
            if (loaded) begin
                m_acc = m_acc + m_y;
                if (m_acc > AMAX) begin
                    m_acc = AMAX; m_sat = 1;
                end
            end
        end
        #1;
    endtask

    function automatic logic [63:0] therm(input int k);
        logic [63:0] t;
        t = (k >= 64) ? '1 : ((64'd1 << k) - 64'd1);
        return t;
    endfunction

    task automatic test_reset();
        rst0 = 1; set_in(1, 1, '1, 0);
        en1 = 0; vi1 = 0; x1 = '0;
        cyc(); cyc();
        vectors += 4;
        if (vo0 !== 1'b0) begin errs++; $display("FAIL reset valid_o got %0b exp 0", vo0); end
        if (y0 !== 7'd0) begin errs++; $display("FAIL reset y got %0d exp 0", y0); end
        if (acc0 !== 8'd0) begin errs++; $display("FAIL reset acc_o got %0d exp 0", acc0); end
        if (sat0 !== 1'b0) begin errs++; $display("FAIL reset acc_sat got %0b exp 0", sat0); end
        rst0 = 0; set_in(1, 0, '0, 0);
    endtask

    task automatic test_latency();
        bit ev;
        int ey;
        set_in(1, 1, 64'h0, 0); cyc();
        set_in(1, 1, '1, 0);    cyc();
        set_in(1, 0, '0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            vectors++;
            if (vo0 !== m_v) begin errs++; $display("FAIL latency valid_o c%0d got %0b exp %0b", i, vo0, m_v); end
            if (m_v) begin
                vectors++;
                if (y0 !== 7'(m_y)) begin errs++; $display("FAIL latency y c%0d got %0d exp %0d", i, y0, m_y); end
            end
            if (i >= 1 && i <= 3) begin
                ev = (i != 3);
                ey = (i == 2) ? 64 : 0;
                vectors++;
                if (vo0 !== ev || (ev && y0 !== 7'(ey))) begin
                    errs++; $display("FAIL latency_fixed c%0d got v=%0b y=%0d exp v=%0b y=%0d", i, vo0, y0, ev, ey);
                end
            end
        end
    endtask

    task automatic test_stream();
        int ks[8] = '{0, 1, 7, 8, 9, 31, 63, 64};
        int got[$];
        for (int i = 0; i < 8 + LAT + 1; i++) begin
            if (i < 8) set_in(1, 1, therm(ks[i]), 0);
            else       set_in(1, 0, {$urandom, $urandom}, 0);
            cyc();
            vectors += 2;
            if (vo0 !== m_v) begin errs++; $display("FAIL stream valid_o c%0d got %0b exp %0b", i, vo0, m_v); end
            if (acc0 !== 8'(m_acc) || sat0 !== m_sat) begin
                errs++; $display("FAIL stream acc c%0d got %0d/%0b exp %0d/%0b", i, acc0, sat0, m_acc, m_sat);
            end
            if (vo0) got.push_back(int'(y0));
        end
        vectors++;
        if (got.size() != 8) begin
            errs++; $display("FAIL stream count got %0d exp 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (got[i] != ks[i]) begin errs++; $display("FAIL stream order %0d got %0d exp %0d", i, got[i], ks[i]); end
            end
        end
        vectors++;
        if (vo0 !== 1'b0) begin errs++; $display("FAIL stream tail valid_o got %0b exp 0", vo0); end
    endtask

    task automatic test_stall();
        int   exp_q[$];
        int   got[$];
        logic [63:0] xv;
        bit   fv;
        logic [6:0] fy;
        logic [7:0] fa;
        for (int i = 0; i < 3; i++) begin
            xv = {$urandom, $urandom};
            exp_q.push_back($countones(xv));
            set_in(1, 1, xv, 0); cyc();
            if (vo0) got.push_back(int'(y0));
        end
        fv = vo0; fy = y0; fa = acc0;
        for (int i = 0; i < 5; i++) begin
            set_in(0, 1, {$urandom, $urandom}, 0); cyc();
            vectors += 2;
            if (vo0 !== fv || y0 !== fy || acc0 !== fa) begin
                errs++; $display("FAIL stall_freeze c%0d got v=%0b y=%0d a=%0d exp v=%0b y=%0d a=%0d", i, vo0, y0, acc0, fv, fy, fa);
            end
            if (vo0 !== m_v) begin errs++; $display("FAIL stall valid_o c%0d got %0b exp %0b", i, vo0, m_v); end
        end
        for (int i = 0; i < LAT + 2; i++) begin
            set_in(1, 0, '0, 0); cyc();
            vectors += 2;
            if (vo0 !== m_v) begin errs++; $display("FAIL stall drain valid_o c%0d got %0b exp %0b", i, vo0, m_v); end
            if (acc0 !== 8'(m_acc) || sat0 !== m_sat) begin
                errs++; $display("FAIL stall acc c%0d got %0d/%0b exp %0d/%0b", i, acc0, sat0, m_acc, m_sat);
            end
            if (vo0) got.push_back(int'(y0));
        end
        vectors++;
        if (got.size() != 3) begin
            errs++; $display("FAIL stall count got %0d exp 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (got[i] != exp_q[i]) begin errs++; $display("FAIL stall order %0d got %0d exp %0d", i, got[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_accum();
        for (int c = 0; c < 10; c++) begin
            if (c == 0)      set_in(1, 0, '0, 1);
            else if (c <= 4) set_in(1, 1, '1, 0);
            else if (c == 5) set_in(1, 1, 64'h1F, 0);
            else             set_in(1, 0, '0, c == 8);
            cyc();
            vectors++;
            if (acc0 !== 8'(m_acc) || sat0 !== m_sat) begin
                errs++; $display("FAIL accum c%0d got %0d/%0b exp %0d/%0b", c, acc0, sat0, m_acc, m_sat);
            end
            if (c == 7) begin
                vectors++;
                if (acc0 !== 8'd255 || sat0 !== 1'b1) begin errs++; $display("FAIL accum_sat got %0d/%0b exp 255/1", acc0, sat0); end
            end
            if (c == 8) begin
                vectors++;
                if (acc0 !== 8'd5 || sat0 !== 1'b0) begin errs++; $display("FAIL accum_clr_add got %0d/%0b exp 5/0", acc0, sat0); end
            end
        end
    endtask

    task automatic test_nonpow2();
        ent_t q1[$];
        set_in(0, 0, '0, 0);
        en1 = 1;
        for (int c = 0; c < 24; c++) begin
            if (c == 0)      begin x1 = 13'h1FFF; vi1 = 1; end
            else if (c == 1) begin x1 = 13'h1001; vi1 = 1; end
            else             begin x1 = 13'($urandom); vi1 = 1'($urandom); end
            q1.push_back('{vi1, $countones(x1)});
            if (q1.size() > LAT1) void'(q1.pop_front());
            cyc();
            vectors++;
            if (vo1 !== (q1.size() == LAT1 && q1[0].v)) begin
                errs++; $display("FAIL np2 valid_o c%0d got %0b", c, vo1);
            end
            if (q1.size() == LAT1 && q1[0].v) begin
                vectors++;
                if (y1 !== 5'(q1[0].c)) begin errs++; $display("FAIL np2 y c%0d got %0d exp %0d", c, y1, q1[0].c); end
            end
            if (c == 2 || c == 3) begin
                vectors++;
                if (vo1 !== 1'b1 || y1 !== ((c == 2) ? 5'd13 : 5'd2)) begin
                    errs++; $display("FAIL np2_fixed c%0d got v=%0b y=%0d exp v=1 y=%0d", c, vo1, y1, (c == 2) ? 13 : 2);
                end
            end
        end
        en1 = 0; vi1 = 0;
    endtask

    task automatic test_reset_mid();
        set_in(1, 1, {$urandom, $urandom}, 0); cyc();
        set_in(1, 1, {$urandom, $urandom}, 0); cyc();
        rst0 = 1; set_in(1, 0, '0, 0); cyc();
        rst0 = 0;
        for (int i = 0; i < LAT + 1; i++) begin
            cyc();
            vectors += 2;
            if (vo0 !== 1'b0) begin errs++; $display("FAIL rst_mid valid_o c%0d got %0b exp 0", i, vo0); end
            if (acc0 !== 8'd0 || sat0 !== 1'b0) begin errs++; $display("FAIL rst_mid acc c%0d got %0d/%0b exp 0/0", i, acc0, sat0); end
        end
    endtask

    task automatic test_random();
        logic [63:0] xv;
        for (int i = 0; i < 400; i++) begin
            xv = ($urandom_range(3) == 0) ? therm($urandom_range(64)) : {$urandom, $urandom};
            rst0 = ($urandom_range(99) < 2);
            set_in($urandom_range(99) < 85, $urandom_range(99) < 70, xv, $urandom_range(99) < 5);
            cyc();
            vectors += 2;
            if (vo0 !== m_v) begin errs++; $display("FAIL rand valid_o c%0d got %0b exp %0b", i, vo0, m_v); end
            if (m_v) begin
                vectors++;
                if (y0 !== 7'(m_y)) begin errs++; $display("FAIL rand y c%0d got %0d exp %0d", i, y0, m_y); end
            end
            if (acc0 !== 8'(m_acc) || sat0 !== m_sat) begin
                errs++; $display("FAIL rand acc c%0d got %0d/%0b exp %0d/%0b", i, acc0, sat0, m_acc, m_sat);
            end
        end
        rst0 = 0;
    endtask

    initial begin
        rst0 = 1; en0 = 0; vi0 = 0; x0 = '0; clr0 = 0;
        en1 = 0; vi1 = 0; x1 = '0;
        m_v = 0; m_y = 0; m_acc = 0; m_sat = 0;
        #1;
        test_reset();
        test_latency();
        test_stream();
        test_stall();
        test_accum();
        test_nonpow2();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/pop_count_pipe.md
Name: pop_count_pipe

Overview:
- Parameterised, fully pipelined population counter for wide thermometer or bubble codes from the TDC delay line. Successor to the single-register pop counter.
- The input word is split into fixed-width leaf groups and summed by a registered adder tree.
- A valid flag travels alongside the data, and a global enable stalls the whole pipeline.
- An optional saturating accumulator sums successive results, used for code-density and calibration runs.

Parameters:
- N, 64, input word width; any value ≥1.
- LEAF_W, 8, bits per leaf group; 1 ≤ LEAF_W ≤ N.
- ACC_W, 16, accumulator width; must be ≥ $clog2(N)+1.
- Derived localparams (not overridable):
  - G = ceil(N/LEAF_W)
  - L = $clog2(G)
  - LATENCY = L+1
  - YW = $clog2(N)+1

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- en  input  1  pipeline advance; 0 = all stages hold
- valid_i  input  1  x carries a sample this cycle
- x  input  N  code word to count
- acc_clr  input  1  synchronous accumulator clear
- valid_o  output  1  y holds a valid result
- y  output  YW  ones count of the sample issued LATENCY advances earlier
- acc_o  output  ACC_W  saturating sum of all valid y since last clear/reset
- acc_sat  output  1  sticky: accumulator has saturated

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst, sampled at the rising edge; it has priority over every other input.
- Reset values: valid_o=0, y=0, acc_o=0, acc_sat=0. All internal stage data and stage valid flags are also cleared.
- Padding: x is zero-extended to G_P = 2^L leaf groups of LEAF_W bits. Padding bits never contribute to the count.
- Stage 0 (leaf): each group's ones count is computed combinationally and registered. Width is $clog2(LEAF_W)+1.
- Stages 1..L: each stage registers pairwise sums of the previous stage. Each level's width is one bit wider than the level before, and carries are never truncated.
- The final stage register is y. If L=0, y is the registered leaf count (LATENCY=1).
- A valid bit accompanies every stage. valid_i enters at stage 0; valid_o is the valid bit of the last stage.
- Stage data registers load on every advance regardless of valid, so y is defined even when valid_o=0. Verification checks y only when valid_o=1.
- When en=1, all stages advance one step per cycle. Throughput is one sample per cycle, with no bubbles inserted.
- When en=0, every stage register holds, including all valid bits, y, valid_o and the accumulator. x and valid_i are ignored.
- A sample presented with valid_i=1 and en=1 on edge k appears with valid_o=1 after the LATENCY-th advancing edge counted from k, inclusive. With en held at 1, that is edge k+LATENCY-1.
- Accumulator update rule: it updates on the same edge that loads a valid result into y, i.e. en=1 and the pre-final stage valid = 1. On that edge, acc_o <= acc_o + new_y.
- Saturation: if the true sum exceeds 2^ACC_W-1, acc_o <= all-ones and acc_sat <= 1. Once saturated, acc_o stays at all-ones until cleared.
- acc_clr acts regardless of en.
  - With no coincident valid result, acc_clr sets acc_o=0 and acc_sat=0.
  - With a coincident valid load, clear-then-add applies: acc_o <= new_y and acc_sat <= 0.
- Reset asserted mid-stream flushes every in-flight sample. No valid_o is produced for samples accepted before reset.
- Inputs are assumed free of X. A property checker compares y against $countones of the matching input; it is active when valid_o=1 and disabled during rst.

Test Plan:
- Reset and latency, N=64 and LEAF_W=8 (LATENCY=4): after rst, issue x=64'h0 then x=64'hFFFF_FFFF_FFFF_FFFF with en=1. valid_o rises 3 edges after first issue; y=0 then y=64 on consecutive cycles.
- Streaming: issue 8 back-to-back thermometer codes with 0, 1, 7, 8, 9, 31, 63 and 64 ones. Outputs appear in order, one per cycle, with the exact counts; then valid_o=0.
- Stall: issue 3 samples, deassert en for 5 cycles mid-flight, then reassert. y, valid_o and acc_o are frozen during the stall, and no result is lost or duplicated. Total output order is preserved.
- Non-power-of-two N=13, LEAF_W=4 (G=4, L=2, LATENCY=3, YW=5): x=13'h1FFF gives y=13, and x=13'h1001 gives y=2. Padding bits never counted.
- Accumulator, ACC_W=8, N=64: stream four all-ones words, giving acc_o=255 with acc_sat=1 after the 4th (sum 256 saturates). Assert acc_clr on the cycle a y=5 result loads: acc_o=5, acc_sat=0.
- Reset mid-operation: issue 2 valid samples, assert rst one cycle later. valid_o stays 0 for the next LATENCY cycles after rst drops, and acc_o=0.
